// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU: opcode encoding (matches the ALU),
// sequencer phase encoding, and the ALU-operation classifier.
package cpu_pkg;

   typedef enum logic [2:0] {
      HLT = 3'd0,
      SKZ = 3'd1,
      ADD = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      LDA = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcode_t;

   typedef enum logic [3:0] {
      INST_ADDR  = 4'd0,
      INST_FETCH = 4'd1,
      INST_LOAD  = 4'd2,
      IDLE       = 4'd3,
      OP_ADDR    = 4'd4,
      OP_FETCH   = 4'd5,
      ALU_OP     = 4'd6,
      STORE      = 4'd7,
      HALTED     = 4'd8
   } phase_t;

   // Opcodes whose result is written back into the accumulator from memory/ALU
   function automatic logic is_aluop(input opcode_t op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction

endpackage

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer for the 8-bit accumulator CPU.
// One phase register; all strobes are a combinational decode of the phase,
// the IR opcode and the ALU zero flag, so reset forces them at once.
module cpu_controller
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [2:0] opcode,
   input  logic       is_zero,
   output logic       sel,
   output logic       rd,
   output logic       wr,
   output logic       ld_ir,
   output logic       ld_ac,
   output logic       ld_pc,
   output logic       inc_pc,
   output logic       data_e,
   output logic       halt
);

   phase_t  phase;
   phase_t  phase_nxt;
   opcode_t op;
   logic    aluop;

   assign op    = opcode_t'(opcode);
   assign aluop = is_aluop(op);

   // Next-phase selection: linear walk, HLT diverts to HALTED, HALTED is sticky
   always_comb begin
      phase_nxt = phase;
      if (phase != HALTED && enable) begin
         case (phase)
            INST_ADDR:  phase_nxt = INST_FETCH;
            INST_FETCH: phase_nxt = INST_LOAD;
            INST_LOAD:  phase_nxt = IDLE;
            IDLE:       phase_nxt = OP_ADDR;
            OP_ADDR:    phase_nxt = (op == HLT) ? HALTED : OP_FETCH;
            OP_FETCH:   phase_nxt = ALU_OP;
            ALU_OP:     phase_nxt = STORE;
            STORE:      phase_nxt = INST_ADDR;
            default:    phase_nxt = HALTED;
         endcase
      end
   end

   // Phase register; reset aborts whatever instruction is in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) phase <= INST_ADDR;
      else        phase <= phase_nxt;
   end

   // Strobe decode from the current phase
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      wr     = 1'b0;
      ld_ir  = 1'b0;
      ld_ac  = 1'b0;
      ld_pc  = 1'b0;
      inc_pc = 1'b0;
      data_e = 1'b0;
      halt   = 1'b0;
      case (phase)
         INST_ADDR: begin
            sel = 1'b1;
         end
         INST_FETCH: begin
            sel = 1'b1;
            rd  = 1'b1;
         end
         INST_LOAD, IDLE: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
         end
         OP_ADDR: begin
            inc_pc = 1'b1;
            halt   = (op == HLT);
         end
         OP_FETCH: begin
            rd = aluop;
         end
         ALU_OP: begin
            rd     = aluop;
            // Second PC increment skips the next instruction when AC == 0
            inc_pc = (op == SKZ) && is_zero;
            ld_pc  = (op == JMP);
            data_e = (op == STO);
         end
         STORE: begin
            rd     = aluop;
            ld_ac  = aluop;
            // JMP reloads the same target again; harmless and keeps decode flat
            ld_pc  = (op == JMP);
            wr     = (op == STO);
            data_e = (op == STO);
         end
         HALTED: begin
            halt = 1'b1;
         end
         default: begin
            halt = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: a driver applies inputs on the falling
// edge and queues the strobes the reference model expects for that cycle; a
// monitor samples the outputs shortly after and compares in order.
module tb_cpu_controller;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic [2:0] opcode;
   logic       is_zero;
   logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;

   cpu_controller dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .opcode  (opcode),
      .is_zero (is_zero),
      .sel     (sel),
      .rd      (rd),
      .wr      (wr),
      .ld_ir   (ld_ir),
      .ld_ac   (ld_ac),
      .ld_pc   (ld_pc),
      .inc_pc  (inc_pc),
      .data_e  (data_e),
      .halt    (halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] bits;
      string      tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_pass  = 0;
   bit   drv_done = 0;

   // Model state: how many enabled cycles into the instruction (0..7),
   // or 8 meaning halted.
   int   step_no = 0;

   localparam int HALT_STEP = 8;

   // Expected strobes {sel,rd,wr,ld_ir,ld_ac,ld_pc,inc_pc,data_e,halt} for
   // cycle n of an instruction, written from the instruction-timing table.
   function automatic logic [8:0] model_out(int n, logic [2:0] op, logic z);
      logic m_sel, m_rd, m_wr, m_ir, m_ac, m_pc, m_inc, m_de, m_halt;
      bit   writes_ac;
      writes_ac = (op >= 3'd2 && op <= 3'd5);
      m_sel  = (n <= 3);
      m_rd   = (n >= 1 && n <= 3) || (n >= 5 && n <= 7 && writes_ac);
      m_ir   = (n == 2 || n == 3);
      m_inc  = (n == 4) || (n == 6 && op == 3'd1 && z);
      m_halt = (n == HALT_STEP) || (n == 4 && op == 3'd0);
      m_ac   = (n == 7 && writes_ac);
      m_pc   = (op == 3'd7) && (n == 6 || n == 7);
      m_de   = (op == 3'd6) && (n == 6 || n == 7);
      m_wr   = (op == 3'd6) && (n == 7);
      return {m_sel, m_rd, m_wr, m_ir, m_ac, m_pc, m_inc, m_de, m_halt};
   endfunction

   // One cycle: drive at the falling edge, queue expectation, advance model
   task automatic step(input logic en, input logic rn, input logic [2:0] op,
                       input logic z, input string tag);
      exp_t e;
      @(negedge clk);
      enable  = en;
      rst_n   = rn;
      opcode  = op;
      is_zero = z;
      if (!rn) step_no = 0;
      e.bits = model_out(step_no, op, z);
      e.tag  = tag;
      exp_q.push_back(e);
      @(posedge clk);
      if (!rn)                     step_no = 0;
      else if (step_no == HALT_STEP) step_no = HALT_STEP;
      else if (en) begin
         if (step_no == 4 && op == 3'd0) step_no = HALT_STEP;
         else                            step_no = (step_no + 1) % 8;
      end
   endtask

   task automatic run_instr(input logic [2:0] op, input logic z, input string tag);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, op, z, tag);
   endtask

   // Monitor: compare sampled outputs against the queued expectations
   initial begin
      logic [8:0] got;
      exp_t       e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};
            n_total++;
            if (got === e.bits) n_pass++;
            else $display("FAIL %s: got strobes %b expected %b (t=%0t)",
                          e.tag, got, e.bits, $time);
         end
      end
   end

   // Watchdog keeps the run bounded
   initial begin
      #500000;
      $display("FAIL watchdog: bench did not complete, got timeout expected finish");
      $fatal(1, "timeout");
   end

   // Stimulus
   initial begin
      logic [2:0] rop;
      rst_n   = 1'b0;
      enable  = 1'b0;
      opcode  = 3'd2;
      is_zero = 1'b0;

      // Reset held, then a plain ADD
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd2, 1'b0, "reset");
      run_instr(3'd2, 1'b0, "add");
      step(1'b1, 1'b1, 3'd2, 1'b0, "wrap");
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 3'd2, 1'b0, "add2");

      // SKZ taken and not taken, STO, JMP
      run_instr(3'd1, 1'b1, "skz_taken");
      run_instr(3'd1, 1'b0, "skz_not");
      run_instr(3'd6, 1'b0, "sto");
      run_instr(3'd7, 1'b1, "jmp");

      // Stall in ALU_OP for 4 cycles, then finish the instruction
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 3'd1, 1'b1, "pre_stall");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'd1, 1'b1, "stall_alu");
      for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 3'd1, 1'b1, "post_stall");

      // STO into STORE, stall there (wr held), then reset mid-cycle
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 3'd6, 1'b0, "sto_pre");
      step(1'b0, 1'b1, 3'd6, 1'b0, "sto_stall");
      step(1'b1, 1'b0, 3'd6, 1'b0, "async_rst_store");
      step(1'b1, 1'b0, 3'd6, 1'b0, "rst_hold");
      run_instr(3'd4, 1'b0, "xor_after_rst");

      // Randomized instructions with random stalls
      for (int k = 0; k < 300; k++) begin
         if (step_no == 0) begin
            rop = 3'($urandom_range(1, 7));
            opcode = rop;
         end else begin
            rop = opcode;
         end
         step(($urandom_range(0, 3) != 0), 1'b1, rop, 1'($urandom_range(0, 1)), "random");
      end
      while (step_no != 0) step(1'b1, 1'b1, opcode, 1'b0, "drain");

      // HLT: reaches HALTED, enable ignored, only reset leaves
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3'd0, 1'b0, "hlt_enter");
      for (int i = 0; i < 20; i++)
         step(1'($urandom_range(0, 1)), 1'b1, 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), "halted");
      step(1'b1, 1'b0, 3'd2, 1'b0, "halt_rst");
      run_instr(3'd2, 1'b0, "add_after_halt");

      @(negedge clk);
      #4;
      n_total++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Eight-phase instruction sequencer for the 8-bit accumulator CPU. It drives the datapath control strobes: memory read/write, IR/PC/AC load, PC increment, address-mux select, data bus enable and halt. It consumes the opcode held in the instruction register and the accumulator-zero flag produced by the ALU. It sits between the instruction register/ALU and the PC, memory and accumulator registers, and is the control-side counterpart of the ALU's opcode/is_zero interface.

## Interface
Parameters: none. Opcode width is fixed at 3 bits.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  phase advance enable; 0 = stall, which holds the phase and holds all outputs
- opcode  in  3  current instruction opcode from the IR; must be stable from IDLE through STORE
- is_zero  in  1  accumulator == 0, taken from the ALU
- sel  out  1  address mux: 1 = PC, 0 = IR operand field
- rd  out  1  memory read
- wr  out  1  memory write
- ld_ir  out  1  load the instruction register
- ld_ac  out  1  load the accumulator from the ALU result
- ld_pc  out  1  load the PC from the IR operand
- inc_pc  out  1  PC += 1
- data_e  out  1  drive the accumulator onto the data bus
- halt  out  1  CPU halted

## Operation
- State: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, HALTED.
- With enable=1, the states advance in the listed order and STORE wraps to INST_ADDR.
- In OP_ADDR with opcode=HLT, the next state is HALTED. HALTED is left only by reset, and enable is ignored there.
- ALUOP is defined as opcode ∈ {ADD, AND, XOR, LDA}.
- Outputs are decoded combinationally from the registered state, opcode and is_zero. Any output not listed for a state is 0.
- Per-state outputs:
  - INST_ADDR: sel.
  - INST_FETCH: sel, rd.
  - INST_LOAD: sel, rd, ld_ir.
  - IDLE: sel, rd, ld_ir.
  - OP_ADDR: inc_pc; halt is 1 when opcode=HLT.
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && is_zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
  - STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
  - HALTED: halt.
- is_zero is only sampled during ALU_OP with opcode=SKZ. In that cycle the PC is incremented a second time, which skips the next instruction.
- Opcodes HLT, SKZ, JMP and STO never assert ld_ac. STO never asserts rd in OP_FETCH.
- There is no illegal opcode: all 8 encodings are defined.

## Timing
- Reset (asynchronous, whenever rst_n=0): state goes to INST_ADDR immediately, so sel=1 and every other output is 0.
- Leaving reset: the first enabled edge after rst_n rises moves to INST_FETCH.
- Reset mid-instruction (any state, including HALTED) aborts the instruction. No wr is issued after rst_n falls.
- One instruction takes exactly 8 enabled cycles. HLT takes 5 cycles to reach HALTED: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, then HALTED.
- With enable=0, the state holds and the outputs stay at that state's decode. A stall in STORE with STO therefore holds wr high; the memory must tolerate a repeated write.
- Strobe timing: ld_ir, ld_ac, ld_pc and inc_pc take effect at the rising edge that ends the cycle in which they are high. Per instruction, inc_pc is a single pulse, except for a taken SKZ, which gives two pulses.
- JMP: ld_pc is high in both ALU_OP and STORE, so the PC is loaded twice with the same value. This is idempotent and intentional.

## Structure
- The shared package cpu_pkg holds:
  - opcode_t enum (3 bits): HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7, matching the ALU encoding.
  - phase_t enum (4 bits): INST_ADDR=0 … STORE=7, HALTED=8.
  - The ALUOP helper function.
- No sub-module. There is one state register plus the output decode; expected size is about 150 lines.

## Test plan
- Reset and idle: hold rst_n=0 for 3 cycles, then release with enable=1. Expect sel=1 with all else 0, then the 8-state sequence, then a wrap to INST_ADDR on cycle 8.
- ADD, opcode=2: rd is high in cycles 1-3 and 5-7; ld_ir is high in cycles 2-3; inc_pc only in cycle 4; ld_ac only in cycle 7; wr is never high.
- SKZ, opcode=1: with is_zero=1, inc_pc is high in cycles 4 and 6. With is_zero=0, inc_pc is high in cycle 4 only.
- STO, opcode=6: data_e is high in cycles 6-7; wr only in cycle 7; rd is 0 in cycles 5-7. JMP, opcode=7: ld_pc is high in cycles 6-7 and ld_ac is never high.
- HLT, opcode=0: halt and inc_pc are high in cycle 4. From cycle 5 onward, halt=1 and all else 0 for 20 cycles. A rst_n pulse then returns to INST_ADDR.
- Stall and async reset: drop enable in ALU_OP for 4 cycles and check the state and outputs are frozen. Assert rst_n=0 mid-cycle in STORE and check the outputs change before the next clock edge.
